// File: rtl/agc_pkg.sv
// agc_pkg: shared mode encodings and width/saturation helpers for the AGC loop blocks
package agc_pkg;
  localparam logic [1:0] AGC_MODE_ACC  = 2'b00;
  localparam logic [1:0] AGC_MODE_HOLD = 2'b01;
  localparam logic [1:0] AGC_MODE_CLR  = 2'b10;
  localparam int SAT_MAXW = 128;
  function automatic int agc_clog2w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
  function automatic logic [SAT_MAXW-1:0] sat_max(input int w);
    return (SAT_MAXW'(1) << (w - 1)) - SAT_MAXW'(1);
  endfunction
  function automatic logic [SAT_MAXW-1:0] sat_min(input int w);
    return -(SAT_MAXW'(1) << (w - 1));
  endfunction
endpackage

// File: rtl/agc_sat_add.sv
// agc_sat_add: W-bit signed add evaluated at W+1 bits, clamped to the W-bit range with an overflow flag
module agc_sat_add import agc_pkg::*; #(
  parameter int W = 48
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y,
  output logic                ovf
);
  localparam logic [SAT_MAXW-1:0] MAXF = sat_max(W);
  localparam logic [SAT_MAXW-1:0] MINF = sat_min(W);
  logic signed [W:0] s;
  assign s   = {a[W-1], a} + {b[W-1], b};
  assign ovf = s[W] ^ s[W-1];
  assign y   = ovf ? (s[W] ? MINF[W-1:0] : MAXF[W-1:0]) : s[W-1:0];
endmodule

// File: rtl/agc_error_mc.sv
// agc_error_mc: multi-channel AGC loop error integrator, acc[ch] += coeff*(r_level-data) with saturation
module agc_error_mc import agc_pkg::*; #(
  parameter int AWIDTH   = 27,
  parameter int DWIDTH   = 8,
  parameter int BWIDTH   = 13,
  parameter int OUTWIDTH = 48,
  parameter int NUM_CH   = 4,
  localparam int CHW     = agc_clog2w(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_in,
  input  logic [CHW-1:0]             ch_in,
  input  logic signed [AWIDTH-1:0]   data_in,
  input  logic [DWIDTH-1:0]          r_level,
  input  logic [BWIDTH-1:0]          coeff,
  input  logic [1:0]                 mode,
  input  logic                       clear_all,
  output logic                       valid_out,
  output logic [CHW-1:0]             ch_out,
  output logic signed [OUTWIDTH-1:0] error_out,
  output logic                       sat_flag
);
  logic                       v1, v2, v3;
  logic [CHW-1:0]             ch1, ch2, ch3;
  logic [1:0]                 m1, m2, m3;
  logic signed [AWIDTH-1:0]   d1;
  logic [DWIDTH-1:0]          r1;
  logic [BWIDTH-1:0]          c1, c2;
  logic signed [AWIDTH+1:0]   diff;
  logic signed [OUTWIDTH-1:0] prod;
  logic signed [OUTWIDTH-1:0] acc [NUM_CH];
  logic signed [OUTWIDTH-1:0] cur, sum;
  logic                       ovf;
  assign cur = acc[ch3];
  agc_sat_add #(.W(OUTWIDTH)) u_sat (.a(cur), .b(prod), .y(sum), .ovf(ovf));
  // S1..S3: capture, form the level error, scale by the loop coefficient
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {v1, v2, v3} <= '0;
      {ch1, ch2, ch3, m1, m2, m3} <= '0;
      {d1, r1, c1, c2, diff, prod} <= '0;
    end else begin
      v1   <= valid_in && ({1'b0, ch_in} < (CHW+1)'(NUM_CH));
      ch1  <= ch_in;
      m1   <= mode;
      d1   <= data_in;
      r1   <= r_level;
      c1   <= coeff;
      v2   <= v1;
      ch2  <= ch1;
      m2   <= m1;
      c2   <= c1;
      diff <= (AWIDTH+2)'($signed({1'b0, r1})) - (AWIDTH+2)'(d1);
      v3   <= v2;
      ch3  <= ch2;
      m3   <= m2;
      prod <= OUTWIDTH'($signed({1'b0, c2})) * OUTWIDTH'(diff);
    end
  end
  // S4: update the channel integrator and register the result; clear_all overrides everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
      valid_out <= 1'b0;
      ch_out    <= '0;
      error_out <= '0;
      sat_flag  <= 1'b0;
    end else begin
      if (clear_all)
        for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
      else if (v3 && m3 == AGC_MODE_ACC)
        acc[ch3] <= sum;
      else if (v3 && m3 == AGC_MODE_CLR)
        acc[ch3] <= '0;
      valid_out <= v3;
      if (v3) begin
        ch_out    <= ch3;
        error_out <= clear_all ? '0 : m3 == AGC_MODE_ACC ? sum : m3 == AGC_MODE_CLR ? '0 : cur;
        sat_flag  <= !clear_all && m3 == AGC_MODE_ACC && ovf;
      end
    end
  end
endmodule

// File: tb/tb_agc_error_mc.sv
// tb_agc_error_mc: directed test-plan steps plus random traffic against a per-channel arithmetic model
module tb_agc_error_mc;
  localparam int AW = 27, DW = 8, BW = 13, OW = 44, NCH = 3, CW = 2;
  localparam longint MAXV = (64'sd1 <<< (OW - 1)) - 64'sd1;
  localparam longint MINV = -(64'sd1 <<< (OW - 1));
  logic clk = 1'b0, rst = 1'b0, valid_in = 1'b0, clear_all = 1'b0;
  logic [CW-1:0] ch_in = '0;
  logic signed [AW-1:0] data_in = '0;
  logic [DW-1:0] r_level = '0;
  logic [BW-1:0] coeff = '0;
  logic [1:0] mode = '0;
  logic valid_out, sat_flag;
  logic [CW-1:0] ch_out;
  logic signed [OW-1:0] error_out;
  agc_error_mc #(.AWIDTH(AW), .DWIDTH(DW), .BWIDTH(BW), .OUTWIDTH(OW), .NUM_CH(NCH)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ch_in(ch_in), .data_in(data_in),
    .r_level(r_level), .coeff(coeff), .mode(mode), .clear_all(clear_all),
    .valid_out(valid_out), .ch_out(ch_out), .error_out(error_out), .sat_flag(sat_flag));
  always #5 clk = ~clk;
  typedef struct {int due; int ch; int md; longint prod;} item_t;
  typedef struct {int ch; longint err; bit sat;} out_t;
  item_t pend[$];
  out_t olog[$];
  longint acc[NCH];
  longint last_err = 0;
  int last_ch = 0, cyc = 0, checks = 0, failures = 0;
  bit last_sat = 0;
  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask
  task automatic step();
    bit v, exp_v;
    item_t it;
    longint s;
    v = valid_in && int'(ch_in) < NCH;
    exp_v = 0;
    @(posedge clk);
    cyc++;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      it = pend.pop_front();
      exp_v = 1;
      last_ch = it.ch;
      if (clear_all) begin
        last_err = 0; last_sat = 0;
      end else if (it.md == 0) begin
        s = acc[it.ch] + it.prod;
        last_sat = s > MAXV || s < MINV;
        s = s > MAXV ? MAXV : s < MINV ? MINV : s;
        acc[it.ch] = s; last_err = s;
      end else if (it.md == 2) begin
        acc[it.ch] = 0; last_err = 0; last_sat = 0;
      end else begin
        last_err = acc[it.ch]; last_sat = 0;
      end
    end
    if (clear_all) foreach (acc[i]) acc[i] = 0;
    if (v) pend.push_back('{cyc + 3, int'(ch_in), int'(mode),
                            longint'(coeff) * (longint'(r_level) - longint'(data_in))});
    @(negedge clk);
    chk("valid_out", longint'(valid_out), longint'(exp_v));
    chk("ch_out", longint'(ch_out), longint'(last_ch));
    chk("error_out", longint'(error_out), last_err);
    chk("sat_flag", longint'(sat_flag), longint'(last_sat));
    if (valid_out) olog.push_back('{int'(ch_out), longint'(error_out), sat_flag});
  endtask
  task automatic send(input int ch, input longint r, input longint d, input longint c, input int md);
    valid_in = 1'b1; ch_in = CW'(ch); r_level = DW'(r); data_in = AW'(d); coeff = BW'(c); mode = 2'(md);
    step();
    valid_in = 1'b0;
  endtask
  task automatic idle(input int n);
    valid_in = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic chk_log(input string tag, input int idx, input int ch, input longint err, input bit sat);
    if (idx >= olog.size()) begin
      chk({tag, "_present"}, longint'(olog.size()), longint'(idx + 1));
    end else begin
      chk({tag, "_ch"}, longint'(olog[idx].ch), longint'(ch));
      chk({tag, "_err"}, olog[idx].err, err);
      chk({tag, "_sat"}, longint'(olog[idx].sat), longint'(sat));
    end
  endtask
  initial begin
    foreach (acc[i]) acc[i] = 0;
    #1 rst = 1'b1;
    #2;
    chk("rst_valid", longint'(valid_out), 0);
    chk("rst_err", longint'(error_out), 0);
    chk("rst_ch", longint'(ch_out), 0);
    chk("rst_sat", longint'(sat_flag), 0);
    @(negedge clk);
    rst = 1'b0;
    olog.delete();
    send(0, 100, 60, 2, 0); send(0, 100, 60, 2, 0); idle(4);
    chk("tp1_count", longint'(olog.size()), 2);
    chk_log("tp1_a", 0, 0, 80, 0);
    chk_log("tp1_b", 1, 0, 160, 0);
    send(0, 0, 0, 0, 2); send(1, 0, 0, 0, 2); idle(4);
    olog.delete();
    send(0, 100, 60, 2, 0); send(1, 10, 50, 3, 0); send(0, 100, 60, 2, 0); send(1, 10, 50, 3, 0); idle(4);
    chk_log("tp2_a", 0, 0, 80, 0);
    chk_log("tp2_b", 1, 1, -120, 0);
    chk_log("tp2_c", 2, 0, 160, 0);
    chk_log("tp2_d", 3, 1, -240, 0);
    olog.delete();
    send(0, 100, 0, 2, 1); send(0, 100, 60, 2, 0); send(0, 100, 60, 2, 2); idle(4);
    chk_log("tp3_hold", 0, 0, 160, 0);
    chk_log("tp3_acc", 1, 0, 240, 0);
    chk_log("tp3_clr", 2, 0, 0, 0);
    olog.delete();
    for (int i = 0; i < 17; i++) send(2, 255, -(64'sd1 <<< 26), 8191, 0);
    idle(4);
    chk_log("tp4_s16", 15, 2, 64'sd8795052699664, 0);
    chk_log("tp4_s17", 16, 2, 64'sd8796093022207, 1);
    send(0, 100, 60, 2, 0); idle(4);
    olog.delete();
    send(0, 100, 60, 2, 0); idle(1); send(0, 100, 60, 2, 0);
    clear_all = 1'b1; idle(1); clear_all = 1'b0; idle(4);
    chk_log("tp5_cleared", 0, 0, 0, 0);
    chk_log("tp5_after", 1, 0, 80, 0);
    olog.delete();
    send(3, 100, 60, 2, 0); idle(5);
    chk("tp6_invalid_ch", longint'(olog.size()), 0);
    send(0, 100, 60, 2, 0); send(1, 100, 60, 2, 0); send(2, 100, 60, 2, 0);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_valid", longint'(valid_out), 0);
    chk("rst_mid_err", longint'(error_out), 0);
    chk("rst_mid_ch", longint'(ch_out), 0);
    chk("rst_mid_sat", longint'(sat_flag), 0);
    pend.delete();
    foreach (acc[i]) acc[i] = 0;
    last_err = 0; last_ch = 0; last_sat = 0;
    @(negedge clk);
    rst = 1'b0;
    olog.delete();
    idle(6);
    chk("tp7_no_valid", longint'(olog.size()), 0);
    for (int i = 0; i < 400; i++) begin
      valid_in  = $urandom_range(0, 3) != 0;
      ch_in     = CW'($urandom_range(0, 3));
      mode      = $urandom_range(0, 5) < 3 ? 2'b00 : 2'($urandom_range(0, 3));
      data_in   = $urandom_range(0, 1) ? AW'($urandom) : -(AW'(1) <<< (AW - 1));
      r_level   = DW'($urandom);
      coeff     = $urandom_range(0, 1) ? BW'($urandom) : BW'(8191);
      clear_all = $urandom_range(0, 31) == 0;
      step();
    end
    valid_in = 1'b0; clear_all = 1'b0;
    idle(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
